// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce: synchronise a raw pin, debounce it with a hold
// counter, and report level, edge pulses, sticky press flag, press count.
//
// Ports:
//   clk          single clock for all logic
//   rst          synchronous, active-high reset
//   gpio_input   raw pin level, asynchronous to clk
//   level_out    debounced level (feeds the Zynq GPIO read input)
//   rise_pulse   one-cycle pulse on an accepted 0->1 change
//   fall_pulse   one-cycle pulse on an accepted 1->0 change
//   event_flag   sticky flag set by each accepted rising edge
//   event_clr    synchronous clear of event_flag (set wins on collision)
//   press_count  wrapping count of accepted rising edges
module gpio_input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int PRESS_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gpio_input,
    output logic               level_out,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic               event_flag,
    input  logic               event_clr,
    output logic [PRESS_W-1:0] press_count
);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRESS_W-1:0] PRESS_ZERO = '0;

    // Synchroniser chain
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_lvl;

    // Debounce FSM
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             diff;

    // Registered outputs
    logic               level_q;
    logic               level_d;
    logic               rise_q;
    logic               rise_d;
    logic               fall_q;
    logic               fall_d;
    logic               flag_q;
    logic               flag_d;
    logic [PRESS_W-1:0] press_q;
    logic [PRESS_W-1:0] press_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_input};
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign diff     = sync_lvl ^ level_q;

    // State register (also holds every other flop)
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            flag_q  <= 1'b0;
            press_q <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            flag_q  <= flag_d;
            press_q <= press_d;
        end
    end

    // Next-state: accept fires on the edge that commits the new level.
    // The STABLE->QUALIFY edge already counts as the first qualifying
    // cycle, so QUALIFY accepts when the count reaches D-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (diff) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (!diff) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Outputs: set of event_flag takes priority over a same-edge clear
    always_comb begin
        level_d = accept ? sync_lvl : level_q;
        rise_d  = accept & sync_lvl;
        fall_d  = accept & ~sync_lvl;
        flag_d  = rise_d | (flag_q & ~event_clr);
        press_d = press_q +
                  {PRESS_ZERO[PRESS_W-1:1], rise_d};
    end

    assign level_out   = level_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign event_flag  = flag_q;
    assign press_count = press_q;

endmodule
